// File: rtl/matmul_core.sv
// Sequential matrix multiplier: C(MxN) = A(MxK) * B(KxN), one data-memory access per cycle.
// Addresses come from running pointers, so there is no multiplier in the address path.
module matmul_core #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 16,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DIM_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DIM_W-1:0]  dim_m,
    input  logic [DIM_W-1:0]  dim_n,
    input  logic [DIM_W-1:0]  dim_k,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] base_c,
    input  logic [DATA_W-1:0] dm_in,
    output logic [ADDR_W-1:0] addr,
    output logic              dm_wr,
    output logic [ACC_W-1:0]  to_mem,
    output logic              busy,
    output logic              done,
    output logic              ovf
);

    typedef enum logic [2:0] {StIdle, StRdA, StRdB, StMac, StWr, StDone} state_t;

    state_t              r_state, w_state_d;
    logic [DIM_W-1:0]    r_dm, w_dm_d, r_dn, w_dn_d, r_dk, w_dk_d;
    logic [DIM_W-1:0]    r_i, w_i_d, r_j, w_j_d, r_k, w_k_d;
    logic [ADDR_W-1:0]   r_base_b, w_base_b_d;
    // a_row = base_a + i*K, a_ptr = a_row + k, b_col = base_b + j, b_ptr = b_col + k*N,
    // c_ptr = base_c + i*N + j
    logic [ADDR_W-1:0]   r_a_row, w_a_row_d, r_a_ptr, w_a_ptr_d;
    logic [ADDR_W-1:0]   r_b_col, w_b_col_d, r_b_ptr, w_b_ptr_d;
    logic [ADDR_W-1:0]   r_c_ptr, w_c_ptr_d;
    logic [ADDR_W-1:0]   r_addr, w_addr_d;
    logic [DATA_W-1:0]   r_a, w_a_d;
    logic [ACC_W-1:0]    r_acc, w_acc_d, r_to_mem, w_to_mem_d;
    logic                r_ovf, w_ovf_d;
    logic [2*DATA_W-1:0] w_prod;
    logic [ACC_W:0]      w_sum;
    logic [ADDR_W-1:0]   w_b_col_inc, w_a_row_next;
    logic                w_k_last, w_j_last, w_i_last;

    assign w_prod       = (2*DATA_W)'(r_a) * (2*DATA_W)'(dm_in);
    // Extra top bit of the sum is the carry out of the accumulator
    assign w_sum        = {1'b0, r_acc} + (ACC_W+1)'(w_prod);
    assign w_b_col_inc  = r_b_col + ADDR_W'(1);
    assign w_a_row_next = r_a_row + ADDR_W'(r_dk);
    assign w_k_last     = (r_k == r_dk - DIM_W'(1));
    assign w_j_last     = (r_j == r_dn - DIM_W'(1));
    assign w_i_last     = (r_i == r_dm - DIM_W'(1));

    // Next-state and datapath updates; addr is loaded with the address of the state being entered
    always_comb begin
        w_state_d  = r_state;
        w_dm_d     = r_dm;
        w_dn_d     = r_dn;
        w_dk_d     = r_dk;
        w_i_d      = r_i;
        w_j_d      = r_j;
        w_k_d      = r_k;
        w_base_b_d = r_base_b;
        w_a_row_d  = r_a_row;
        w_a_ptr_d  = r_a_ptr;
        w_b_col_d  = r_b_col;
        w_b_ptr_d  = r_b_ptr;
        w_c_ptr_d  = r_c_ptr;
        w_addr_d   = r_addr;
        w_a_d      = r_a;
        w_acc_d    = r_acc;
        w_to_mem_d = r_to_mem;
        w_ovf_d    = r_ovf;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_dm_d     = dim_m;
                    w_dn_d     = dim_n;
                    w_dk_d     = dim_k;
                    w_base_b_d = base_b;
                    w_ovf_d    = 1'b0;
                    w_i_d      = '0;
                    w_j_d      = '0;
                    w_k_d      = '0;
                    w_acc_d    = '0;
                    w_a_row_d  = base_a;
                    w_a_ptr_d  = base_a;
                    w_b_col_d  = base_b;
                    w_b_ptr_d  = base_b;
                    w_c_ptr_d  = base_c;
                    if (dim_m == '0 || dim_n == '0 || dim_k == '0) begin
                        w_state_d = StDone;
                    end else begin
                        w_state_d = StRdA;
                        w_addr_d  = base_a;
                    end
                end
            end
            StRdA: begin
                w_state_d = StRdB;
                w_addr_d  = r_b_ptr;
            end
            StRdB: begin
                w_state_d = StMac;
                w_a_d     = dm_in;
            end
            StMac: begin
                w_acc_d = w_sum[ACC_W-1:0];
                if (w_sum[ACC_W]) w_ovf_d = 1'b1;
                if (!w_k_last) begin
                    w_state_d = StRdA;
                    w_k_d     = r_k + DIM_W'(1);
                    w_a_ptr_d = r_a_ptr + ADDR_W'(1);
                    w_b_ptr_d = r_b_ptr + ADDR_W'(r_dn);
                    w_addr_d  = r_a_ptr + ADDR_W'(1);
                end else begin
                    w_state_d  = StWr;
                    w_addr_d   = r_c_ptr;
                    w_to_mem_d = w_sum[ACC_W-1:0];
                end
            end
            StWr: begin
                w_acc_d   = '0;
                w_k_d     = '0;
                w_c_ptr_d = r_c_ptr + ADDR_W'(1);
                if (!w_j_last) begin
                    w_state_d = StRdA;
                    w_j_d     = r_j + DIM_W'(1);
                    w_b_col_d = w_b_col_inc;
                    w_b_ptr_d = w_b_col_inc;
                    w_a_ptr_d = r_a_row;
                    w_addr_d  = r_a_row;
                end else if (!w_i_last) begin
                    w_state_d = StRdA;
                    w_j_d     = '0;
                    w_i_d     = r_i + DIM_W'(1);
                    w_a_row_d = w_a_row_next;
                    w_a_ptr_d = w_a_row_next;
                    w_addr_d  = w_a_row_next;
                    w_b_col_d = r_base_b;
                    w_b_ptr_d = r_base_b;
                end else begin
                    w_state_d = StDone;
                end
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // State and datapath registers, all cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_dm     <= '0;
            r_dn     <= '0;
            r_dk     <= '0;
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_base_b <= '0;
            r_a_row  <= '0;
            r_a_ptr  <= '0;
            r_b_col  <= '0;
            r_b_ptr  <= '0;
            r_c_ptr  <= '0;
            r_addr   <= '0;
            r_a      <= '0;
            r_acc    <= '0;
            r_to_mem <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_dm     <= w_dm_d;
            r_dn     <= w_dn_d;
            r_dk     <= w_dk_d;
            r_i      <= w_i_d;
            r_j      <= w_j_d;
            r_k      <= w_k_d;
            r_base_b <= w_base_b_d;
            r_a_row  <= w_a_row_d;
            r_a_ptr  <= w_a_ptr_d;
            r_b_col  <= w_b_col_d;
            r_b_ptr  <= w_b_ptr_d;
            r_c_ptr  <= w_c_ptr_d;
            r_addr   <= w_addr_d;
            r_a      <= w_a_d;
            r_acc    <= w_acc_d;
            r_to_mem <= w_to_mem_d;
            r_ovf    <= w_ovf_d;
        end
    end

    assign addr   = r_addr;
    assign to_mem = r_to_mem;
    assign ovf    = r_ovf;
    assign dm_wr  = (r_state == StWr);
    assign busy   = (r_state != StIdle);
    assign done   = (r_state == StDone);

endmodule

// File: doc/matmul_core.md
MATMUL_CORE -- requirements
Module: matmul_core

Interface
REQ-001 Parameter DATA_W, 8, width of matrix element read from data memory.
REQ-002 Parameter ACC_W, 16, width of accumulator and result word written to memory.
REQ-003 Parameter ADDR_W, 16, data-memory address width.
REQ-004 Parameter DIM_W, 8, width of each matrix dimension input.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  request a multiply; sampled only in IDLE.
REQ-008 dim_m, dim_n, dim_k  in  DIM_W each  C = A(MxK) * B(KxN).
REQ-009 base_a, base_b, base_c  in  ADDR_W each  word base addresses of A, B, C.
REQ-010 dm_in  in  DATA_W  read data; returns the word addressed in the previous cycle.
REQ-011 addr  out  ADDR_W  registered data-memory address.
REQ-012 dm_wr  out  1  data-memory write strobe.
REQ-013 to_mem  out  ACC_W  write data, valid while dm_wr=1.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle completion pulse.
REQ-016 ovf  out  1  sticky accumulate-overflow flag for the current job.

Function
REQ-017 States SHALL be IDLE, RD_A, RD_B, MAC, WR, DONE.
REQ-018 IDLE with start=1 SHALL latch all dims and bases and clear ovf. If any dim is 0, the next state is DONE; otherwise it is RD_A with i=j=k=0 and acc=0.
REQ-019 start outside IDLE SHALL be ignored; latched dims and bases SHALL not change mid-job.
REQ-020 Each state SHALL last exactly one cycle.
REQ-021 RD_A: addr = base_a + i*K + k.
REQ-022 RD_B: addr = base_b + k*N + j; dm_in (A element) captured into a_reg at end of cycle.
REQ-023 MAC: dm_in (B element) is used; acc <= acc + a_reg*dm_in at end of cycle.
REQ-024 MAC next state: k<K-1 -> RD_A with k+1; else WR.
REQ-025 Addresses SHALL be generated by running pointers (no address multipliers); all address arithmetic wraps modulo 2^ADDR_W.
REQ-026 WR: addr = base_c + i*N + j, dm_wr=1, to_mem=acc.
REQ-027 WR next state: acc cleared and k=0. If j<N-1, j increments and the next state is RD_A. If j=N-1 and i<M-1, j=0, i increments, and the next state is RD_A. Otherwise the next state is DONE.
REQ-028 Multiply is unsigned DATA_W x DATA_W, with a 2*DATA_W product zero-extended to ACC_W.
REQ-029 Accumulate SHALL wrap modulo 2^ACC_W; any carry out of bit ACC_W-1 SHALL set ovf, which holds until the next accepted start or reset.
REQ-030 DONE: done=1 for one cycle, then IDLE.
REQ-031 dm_wr SHALL be 1 only in WR.
REQ-032 to_mem and addr hold their last value outside the states that drive them.
REQ-033 Latency: with start sampled at edge 0, done SHALL be high in cycle M*N*(3K+1)+1 after that edge.
REQ-034 There are exactly M*N writes per job, in row-major order of C.

Reset
REQ-035 rst_n=0 SHALL immediately force IDLE and clear addr, to_mem, acc, a_reg, i, j, k, busy, done, ovf and dm_wr, including mid-job; no write is completed after reset assertion.
REQ-036 After rst_n deasserts, the block SHALL accept start on the first rising edge.

Verification
REQ-037 M=N=K=1, A=255, B=255 -> exactly one write of 65025 to base_c; done in cycle 5; ovf=0.
REQ-038 2x2x2, A=[1,2;3,4], B=identity, base_c=0x0100 -> writes 1,2,3,4 to 0x0100..0x0103 in that order; done in cycle 29.
REQ-039 M=N=1, K=2, all elements 255 -> write 64514 (130050 mod 65536), ovf=1; ovf cleared by next start.
REQ-040 dim_k=0 with start -> done in cycle 1, dm_wr never asserted, busy high for one cycle.
REQ-041 start pulsed again while busy, with different dims -> ignored; outputs identical to the undisturbed job.
REQ-042 rst_n low during the third MAC of a 2x2x2 job -> outputs cleared asynchronously, no further dm_wr; a new job after release yields correct results.
